// File: rtl/mem_access_master_if.sv
// Bundle of request/response handshake and data-memory bus signals for mem_access_master.
// Latency: none; wires only.
// Backpressure: req_ready/rsp_ready carry the valid-ready stalls between datapath and block.
interface mem_access_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [11:0] req_addr;
  logic [15:0] req_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_err;

  logic [11:0] mem_address;
  logic [15:0] mem_data;
  logic        mem_write_enable;
  logic        mem_read_enable;
  logic [15:0] mem_read_data;

  logic        busy;

  // View of the access block itself
  modport master (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_read_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_address, mem_data, mem_write_enable, mem_read_enable, busy
  );

  // View of the surrounding datapath and data memory
  modport slave (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_read_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_address, mem_data, mem_write_enable, mem_read_enable, busy
  );
endinterface

// File: rtl/mem_access_master.sv
// Single-outstanding load/store master between a datapath and a 16-bit data memory (optional MEM_BOUNDS_CHECK_EN).
// Latency: handshake at edge N, one strobe cycle, response valid after edge N+1; 3 cycles minimum per access.
// Backpressure: req_ready only in IDLE; response held in RESP until rsp_ready; no overlap of transactions.
module mem_access_master #(
  parameter int MEM_WORDS = 64
) (
  input  logic clk,
  input  logic rst,
  mem_access_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        handshake;
  logic        out_of_range;
  logic        err_q;
  logic [11:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic        rsp_err_q;

  logic        req_ready_c;
  logic        busy_c;
  logic        rsp_valid_c;
  logic        write_en_c;
  logic        read_en_c;

  // The address bus is 12 bits wide, so a larger memory could never be fully reached.
  if (MEM_WORDS < 1 || MEM_WORDS > 4096) begin : g_bad_mem_words
    $error("mem_access_master: MEM_WORDS must be in 1..4096");
  end

`ifdef MEM_BOUNDS_CHECK_EN
  localparam logic [12:0] WORD_LIMIT = 13'(MEM_WORDS);
  assign out_of_range = ({1'b0, bus.req_addr} >= WORD_LIMIT);
`else
  assign out_of_range = 1'b0;
`endif

  assign handshake = (state == IDLE) && bus.req_valid;

  // State register; reset forces IDLE at once so strobes drop combinationally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and strobes. A rejected request still passes through WRITE/READ with
  // strobes suppressed, which gives it the same response timing as a real access.
  always_comb begin
    state_next  = state;
    req_ready_c = 1'b0;
    busy_c      = 1'b1;
    rsp_valid_c = 1'b0;
    write_en_c  = 1'b0;
    read_en_c   = 1'b0;
    case (state)
      IDLE: begin
        req_ready_c = 1'b1;
        busy_c      = 1'b0;
        if (bus.req_valid) begin
          state_next = bus.req_we ? WRITE : READ;
        end
      end
      WRITE: begin
        write_en_c = !err_q;
        state_next = RESP;
      end
      READ: begin
        read_en_c  = !err_q;
        state_next = RESP;
      end
      RESP: begin
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request latch on handshake and response capture at the close of the strobe cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (handshake) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        err_q   <= out_of_range;
      end
      case (state)
        WRITE: begin
          rdata_q   <= '0;
          rsp_err_q <= err_q;
        end
        READ: begin
          rdata_q   <= err_q ? 16'h0000 : bus.mem_read_data;
          rsp_err_q <= err_q;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rdata_q   <= '0;
            rsp_err_q <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.req_ready        = req_ready_c;
  assign bus.busy             = busy_c;
  assign bus.rsp_valid        = rsp_valid_c;
  assign bus.rsp_rdata        = rdata_q;
  assign bus.rsp_err          = rsp_err_q;
  assign bus.mem_write_enable = write_en_c;
  assign bus.mem_read_enable  = read_en_c;
  assign bus.mem_address      = addr_q;
  assign bus.mem_data         = wdata_q;

endmodule
